// File: rtl/decode_pipe_if.sv
// Fetch-to-execute decode channel: instruction in, decoded bundle out, plus flush.
// The master side is the fetch/execute environment; the slave side is the decode stage.
interface decode_pipe_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned ALU_CTL_W = 5
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instr_raw;
    logic [XLEN-1:0]      pc_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      pc_out;
    logic [XLEN-1:0]      imm;
    logic [ALU_CTL_W-1:0] alu_ctl;
    logic                 alu_src;
    logic                 branch_c;
    logic                 branch_uc;
    logic                 branch_relative;
    logic                 mem_read;
    logic                 mem_write;
    logic [1:0]           mem_size;
    logic                 mem_unsigned;
    logic                 reg_write;
    logic [REG_AW-1:0]    read_reg1;
    logic [REG_AW-1:0]    read_reg2;
    logic [REG_AW-1:0]    write_reg;
    logic                 illegal;

    modport master (
        output flush, in_valid, instr_raw, pc_in, out_ready,
        input  in_ready, out_valid, pc_out, imm, alu_ctl, alu_src, branch_c, branch_uc,
               branch_relative, mem_read, mem_write, mem_size, mem_unsigned, reg_write,
               read_reg1, read_reg2, write_reg, illegal
    );

    modport slave (
        input  flush, in_valid, instr_raw, pc_in, out_ready,
        output in_ready, out_valid, pc_out, imm, alu_ctl, alu_src, branch_c, branch_uc,
               branch_relative, mem_read, mem_write, mem_size, mem_unsigned, reg_write,
               read_reg1, read_reg2, write_reg, illegal
    );
endinterface

// File: rtl/decode_pipe.sv
// Pipelined RV32I decode stage: combinational decode into a registered output bundle
// backed by a one-entry skid buffer, valid/ready on both sides, flush drops everything held.
module decode_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned ALU_CTL_W = 5,
    parameter bit          EN_UPPER  = 1'b1
) (
    input logic           clk,
    input logic           rst,
    decode_pipe_if.slave  bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [ALU_CTL_W-1:0] ALU_ADD     = ALU_CTL_W'(2);
    localparam logic [ALU_CTL_W-1:0] ALU_SUB     = ALU_CTL_W'(3);
    localparam logic [ALU_CTL_W-1:0] ALU_AND     = ALU_CTL_W'(4);
    localparam logic [ALU_CTL_W-1:0] ALU_OR      = ALU_CTL_W'(5);
    localparam logic [ALU_CTL_W-1:0] ALU_XOR     = ALU_CTL_W'(6);
    localparam logic [ALU_CTL_W-1:0] ALU_LT      = ALU_CTL_W'(7);
    localparam logic [ALU_CTL_W-1:0] ALU_GE      = ALU_CTL_W'(8);
    localparam logic [ALU_CTL_W-1:0] ALU_LTU     = ALU_CTL_W'(9);
    localparam logic [ALU_CTL_W-1:0] ALU_CHOOSEB = ALU_CTL_W'(10);
    localparam logic [ALU_CTL_W-1:0] ALU_GEU     = ALU_CTL_W'(11);
    localparam logic [ALU_CTL_W-1:0] ALU_EQ      = ALU_CTL_W'(12);
    localparam logic [ALU_CTL_W-1:0] ALU_NE      = ALU_CTL_W'(13);
    localparam logic [ALU_CTL_W-1:0] ALU_SLL     = ALU_CTL_W'(14);
    localparam logic [ALU_CTL_W-1:0] ALU_SRL     = ALU_CTL_W'(15);
    localparam logic [ALU_CTL_W-1:0] ALU_SRA     = ALU_CTL_W'(16);
    localparam logic [ALU_CTL_W-1:0] ALU_SLT     = ALU_CTL_W'(17);
    localparam logic [ALU_CTL_W-1:0] ALU_SLTU    = ALU_CTL_W'(18);
    localparam logic [ALU_CTL_W-1:0] ALU_ZERO    = ALU_CTL_W'(31);

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      imm;
        logic [ALU_CTL_W-1:0] alu_ctl;
        logic                 alu_src;
        logic                 branch_c;
        logic                 branch_uc;
        logic                 branch_relative;
        logic                 mem_read;
        logic                 mem_write;
        logic [1:0]           mem_size;
        logic                 mem_unsigned;
        logic                 reg_write;
        logic [REG_AW-1:0]    rs1;
        logic [REG_AW-1:0]    rs2;
        logic [REG_AW-1:0]    rd;
        logic                 illegal;
    } bundle_t;

    logic [31:0]        instr;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign instr  = bus.instr_raw;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    bundle_t dec;
    logic    legal;
    logic    writes_rd;

    // Combinational decode of the presented instruction; illegal ones are neutralised at the end.
    always_comb begin
        dec       = '0;
        legal     = 1'b0;
        writes_rd = 1'b0;
        dec.pc      = bus.pc_in;
        dec.rs1     = REG_AW'(instr[19:15]);
        dec.rs2     = REG_AW'(instr[24:20]);
        dec.rd      = REG_AW'(instr[11:7]);
        dec.alu_ctl = ALU_ADD;
        case (opcode)
            OPC_LUI: begin
                legal = EN_UPPER; writes_rd = 1'b1;
                dec.imm = XLEN'(imm_u); dec.alu_ctl = ALU_CHOOSEB; dec.alu_src = 1'b1;
            end
            OPC_AUIPC: begin
                legal = EN_UPPER; writes_rd = 1'b1;
                dec.imm = XLEN'(imm_u); dec.alu_src = 1'b1;
            end
            OPC_JAL: begin
                legal = 1'b1; writes_rd = 1'b1;
                dec.imm = XLEN'(imm_j); dec.alu_ctl = ALU_CHOOSEB; dec.alu_src = 1'b1;
                dec.branch_uc = 1'b1; dec.branch_relative = 1'b1;
            end
            OPC_JALR: begin
                legal = (funct3 == 3'b000); writes_rd = 1'b1;
                dec.imm = XLEN'(imm_i); dec.alu_src = 1'b1; dec.branch_uc = 1'b1;
            end
            OPC_BRANCH: begin
                legal = 1'b1;
                dec.imm = XLEN'(imm_b); dec.branch_c = 1'b1; dec.branch_relative = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_ctl = ALU_EQ;
                    3'b001:  dec.alu_ctl = ALU_NE;
                    3'b100:  dec.alu_ctl = ALU_LT;
                    3'b101:  dec.alu_ctl = ALU_GE;
                    3'b110:  dec.alu_ctl = ALU_LTU;
                    3'b111:  dec.alu_ctl = ALU_GEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                writes_rd = 1'b1;
                dec.imm = XLEN'(imm_i); dec.alu_src = 1'b1; dec.mem_read = 1'b1;
                dec.mem_size = funct3[1:0]; dec.mem_unsigned = funct3[2];
            end
            OPC_STORE: begin
                legal = funct3 inside {3'b000, 3'b001, 3'b010};
                dec.imm = XLEN'(imm_s); dec.alu_src = 1'b1; dec.mem_write = 1'b1;
                dec.mem_size = funct3[1:0];
            end
            OPC_OPIMM: begin
                legal = 1'b1; writes_rd = 1'b1;
                dec.imm = XLEN'(imm_i); dec.alu_src = 1'b1;
                case (funct3)
                    3'b000: dec.alu_ctl = ALU_ADD;
                    3'b010: dec.alu_ctl = ALU_SLT;
                    3'b011: dec.alu_ctl = ALU_SLTU;
                    3'b100: dec.alu_ctl = ALU_XOR;
                    3'b110: dec.alu_ctl = ALU_OR;
                    3'b111: dec.alu_ctl = ALU_AND;
                    3'b001: begin
                        dec.alu_ctl = ALU_SLL;
                        legal = (funct7 == F7_BASE);
                    end
                    default: begin
                        dec.alu_ctl = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                if (funct7 == F7_ALT) begin
                    legal = funct3 inside {3'b000, 3'b101};
                    dec.alu_ctl = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
                end else begin
                    legal = (funct7 == F7_BASE);
                    case (funct3)
                        3'b000:  dec.alu_ctl = ALU_ADD;
                        3'b001:  dec.alu_ctl = ALU_SLL;
                        3'b010:  dec.alu_ctl = ALU_SLT;
                        3'b011:  dec.alu_ctl = ALU_SLTU;
                        3'b100:  dec.alu_ctl = ALU_XOR;
                        3'b101:  dec.alu_ctl = ALU_SRL;
                        3'b110:  dec.alu_ctl = ALU_OR;
                        default: dec.alu_ctl = ALU_AND;
                    endcase
                end
            end
            default: legal = 1'b0;
        endcase
        dec.reg_write = writes_rd && (instr[11:7] != 5'd0);
        if (!legal) begin
            dec.imm             = '0;
            dec.alu_ctl         = ALU_ZERO;
            dec.alu_src         = 1'b0;
            dec.branch_c        = 1'b0;
            dec.branch_uc       = 1'b0;
            dec.branch_relative = 1'b0;
            dec.mem_read        = 1'b0;
            dec.mem_write       = 1'b0;
            dec.mem_size        = 2'b00;
            dec.mem_unsigned    = 1'b0;
            dec.reg_write       = 1'b0;
        end
        dec.illegal = !legal;
    end

    bundle_t out_q, out_d, skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    in_ready_q, in_ready_d;
    logic    accept;
    logic    out_free;

    assign accept   = bus.in_valid && in_ready_q;
    assign out_free = !out_valid_q || bus.out_ready;

    // Next state: skid drains ahead of new input so order is preserved; flush wins over everything.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.pc_out          = out_q.pc;
    assign bus.imm             = out_q.imm;
    assign bus.alu_ctl         = out_q.alu_ctl;
    assign bus.alu_src         = out_q.alu_src;
    assign bus.branch_c        = out_q.branch_c;
    assign bus.branch_uc       = out_q.branch_uc;
    assign bus.branch_relative = out_q.branch_relative;
    assign bus.mem_read        = out_q.mem_read;
    assign bus.mem_write       = out_q.mem_write;
    assign bus.mem_size        = out_q.mem_size;
    assign bus.mem_unsigned    = out_q.mem_unsigned;
    assign bus.reg_write       = out_q.reg_write;
    assign bus.read_reg1       = out_q.rs1;
    assign bus.read_reg2       = out_q.rs2;
    assign bus.write_reg       = out_q.rd;
    assign bus.illegal         = out_q.illegal;
endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed scenarios plus a randomized stream checked against
// an occupancy-queue model of the stage and a field-level RV32I decode model.
module tb_decode_pipe;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  alu_ctl;
        logic        alu_src;
        logic        branch_c;
        logic        branch_uc;
        logic        branch_relative;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        reg_write;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } exp_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    exp_t q[$];
    logic drained;
    logic last_acc;
    exp_t got_drained;
    exp_t exp_drained;

    decode_pipe_if #(.XLEN(32), .REG_AW(5), .ALU_CTL_W(5)) bus ();

    decode_pipe #(.XLEN(32), .REG_AW(5), .ALU_CTL_W(5), .EN_UPPER(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected decode straight from the ISA field layout, immediates via arithmetic shifts.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [31:0] t;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ok;
        logic        wr;
        f3 = ins[14:12];
        f7 = ins[31:25];
        ok = 1'b0;
        wr = 1'b0;
        e = '0;
        e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        case (ins[6:0])
            7'h37: begin ok = 1; wr = 1; e.imm = {ins[31:12], 12'h000}; e.alu_ctl = 10; e.alu_src = 1; end
            7'h17: begin ok = 1; wr = 1; e.imm = {ins[31:12], 12'h000}; e.alu_ctl = 2; e.alu_src = 1; end
            7'h6F: begin
                ok = 1; wr = 1; e.alu_ctl = 10; e.alu_src = 1; e.branch_uc = 1; e.branch_relative = 1;
                t = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'h000};
                e.imm = $signed(t) >>> 11;
            end
            7'h67: begin
                ok = (f3 == 0); wr = 1; e.alu_ctl = 2; e.alu_src = 1; e.branch_uc = 1;
                t = {ins[31:20], 20'h00000}; e.imm = $signed(t) >>> 20;
            end
            7'h63: begin
                ok = 1; e.branch_c = 1; e.branch_relative = 1;
                t = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'h00000};
                e.imm = $signed(t) >>> 19;
                case (f3)
                    0: e.alu_ctl = 12; 1: e.alu_ctl = 13; 4: e.alu_ctl = 7;
                    5: e.alu_ctl = 8;  6: e.alu_ctl = 9;  7: e.alu_ctl = 11;
                    default: ok = 0;
                endcase
            end
            7'h03: begin
                ok = (f3 != 3) && (f3 < 6); wr = 1; e.alu_ctl = 2; e.alu_src = 1; e.mem_read = 1;
                e.mem_size = f3[1:0]; e.mem_unsigned = (f3 >= 4);
                t = {ins[31:20], 20'h00000}; e.imm = $signed(t) >>> 20;
            end
            7'h23: begin
                ok = (f3 < 3); e.alu_ctl = 2; e.alu_src = 1; e.mem_write = 1; e.mem_size = f3[1:0];
                t = {ins[31:25], ins[11:7], 20'h00000}; e.imm = $signed(t) >>> 20;
            end
            7'h13: begin
                ok = 1; wr = 1; e.alu_src = 1;
                t = {ins[31:20], 20'h00000}; e.imm = $signed(t) >>> 20;
                case (f3)
                    0: e.alu_ctl = 2;  2: e.alu_ctl = 17; 3: e.alu_ctl = 18;
                    4: e.alu_ctl = 6;  6: e.alu_ctl = 5;  7: e.alu_ctl = 4;
                    1: begin e.alu_ctl = 14; ok = (f7 == 0); end
                    default: begin
                        if (f7 == 0) e.alu_ctl = 15;
                        else if (f7 == 7'h20) e.alu_ctl = 16;
                        else ok = 0;
                    end
                endcase
            end
            7'h33: begin
                wr = 1;
                if (f7 == 0) begin
                    ok = 1;
                    case (f3)
                        0: e.alu_ctl = 2;  1: e.alu_ctl = 14; 2: e.alu_ctl = 17; 3: e.alu_ctl = 18;
                        4: e.alu_ctl = 6;  5: e.alu_ctl = 15; 6: e.alu_ctl = 5;  default: e.alu_ctl = 4;
                    endcase
                end else if (f7 == 7'h20 && f3 == 0) begin ok = 1; e.alu_ctl = 3; end
                else if (f7 == 7'h20 && f3 == 5) begin ok = 1; e.alu_ctl = 16; end
            end
            default: ok = 0;
        endcase
        e.reg_write = ok && wr && (ins[11:7] != 0);
        if (!ok) begin
            e.imm = 0; e.alu_ctl = 31; e.alu_src = 0; e.branch_c = 0; e.branch_uc = 0;
            e.branch_relative = 0; e.mem_read = 0; e.mem_write = 0; e.mem_size = 0; e.mem_unsigned = 0;
        end
        e.illegal = !ok;
        return e;
    endfunction

    function automatic exp_t get_out();
        exp_t o;
        o.pc = bus.pc_out; o.imm = bus.imm; o.alu_ctl = bus.alu_ctl; o.alu_src = bus.alu_src;
        o.branch_c = bus.branch_c; o.branch_uc = bus.branch_uc; o.branch_relative = bus.branch_relative;
        o.mem_read = bus.mem_read; o.mem_write = bus.mem_write; o.mem_size = bus.mem_size;
        o.mem_unsigned = bus.mem_unsigned; o.reg_write = bus.reg_write;
        o.rs1 = bus.read_reg1; o.rs2 = bus.read_reg2; o.rd = bus.write_reg; o.illegal = bus.illegal;
        return o;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 10))
            0: r[6:0] = 7'h37;
            1: r[6:0] = 7'h17;
            2: r[6:0] = 7'h6F;
            3: r[6:0] = 7'h67;
            4: r[6:0] = 7'h63;
            5: r[6:0] = 7'h03;
            6: r[6:0] = 7'h23;
            7: begin
                r[6:0] = 7'h13;
                if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            end
            8: begin
                r[6:0] = 7'h33;
                if ($urandom_range(0, 4) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        bus.in_valid = v; bus.instr_raw = ins; bus.pc_in = pc; bus.out_ready = ordy; bus.flush = fl;
    endtask

    // Advance one clock; the model decides transfers from its own occupancy, not the DUT's.
    task automatic step();
        logic acc, drn, fl;
        exp_t snap;
        acc  = bus.in_valid && (q.size() < 2);
        drn  = (q.size() > 0) && bus.out_ready;
        fl   = bus.flush;
        snap = get_out();
        @(posedge clk);
        drained  = 1'b0;
        last_acc = acc && !fl;
        if (fl) q.delete();
        else begin
            if (drn) begin drained = 1'b1; got_drained = snap; exp_drained = q.pop_front(); end
            if (acc) q.push_back(ref_decode(bus.instr_raw, bus.pc_in));
        end
        @(negedge clk);
    endtask

    task automatic drain_all();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (4) step();
    endtask

    task automatic test_reset();
        exp_t o;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        o = get_out();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        tests_run++;
        if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        tests_run++;
        if (o !== exp_t'(0)) begin tests_failed++; $display("FAIL reset_bundle got %h exp 0", o); end
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_addi();
        exp_t e;
        drive(1'b1, 32'hFFF08293, 32'h0000_0100, 1'b1, 1'b0);
        e = ref_decode(32'hFFF08293, 32'h0000_0100);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tests_run++;
        if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL addi_valid got %b exp 1", bus.out_valid); end
        tests_run++;
        if (bus.imm !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL addi_imm got %h exp ffffffff", bus.imm); end
        tests_run++;
        if (bus.alu_ctl !== 5'd2 || bus.alu_src !== 1'b1) begin
            tests_failed++; $display("FAIL addi_alu got ctl=%0d src=%b exp ctl=2 src=1", bus.alu_ctl, bus.alu_src);
        end
        tests_run++;
        if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'd5) begin
            tests_failed++; $display("FAIL addi_rd got rw=%b rd=%0d exp rw=1 rd=5", bus.reg_write, bus.write_reg);
        end
        tests_run++;
        if (get_out() !== e) begin tests_failed++; $display("FAIL addi_bundle got %h exp %h", get_out(), e); end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL addi_drain got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_jumps();
        drive(1'b1, 32'h000100E7, 32'h0000_0300, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h0080006F, 32'h0000_0304, 1'b1, 1'b0);
        tests_run++;
        if (bus.branch_uc !== 1'b1 || bus.branch_relative !== 1'b0 || bus.alu_ctl !== 5'd2 || bus.reg_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL jalr_flags got uc=%b rel=%b ctl=%0d rw=%b exp uc=1 rel=0 ctl=2 rw=1",
                     bus.branch_uc, bus.branch_relative, bus.alu_ctl, bus.reg_write);
        end
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tests_run++;
        if (!drained || got_drained !== exp_drained) begin
            tests_failed++; $display("FAIL jalr_bundle got %h exp %h", got_drained, exp_drained);
        end
        tests_run++;
        if (bus.imm !== 32'd8 || bus.reg_write !== 1'b0 || bus.branch_uc !== 1'b1 ||
            bus.branch_relative !== 1'b1 || bus.alu_ctl !== 5'd10) begin
            tests_failed++;
            $display("FAIL jal_fields got imm=%h rw=%b uc=%b rel=%b ctl=%0d exp imm=8 rw=0 uc=1 rel=1 ctl=10",
                     bus.imm, bus.reg_write, bus.branch_uc, bus.branch_relative, bus.alu_ctl);
        end
        drain_all();
    endtask

    task automatic test_illegal();
        logic [31:0] ins [2];
        ins[0] = 32'h1234_567F;
        ins[1] = 32'h022081B3;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ins[i], 32'h400 + 32'(i * 4), 1'b1, 1'b0);
            step();
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.reg_write !== 1'b0 ||
                bus.mem_write !== 1'b0 || bus.alu_ctl !== 5'd31) begin
                tests_failed++;
                $display("FAIL illegal_%0d got v=%b ill=%b rw=%b mw=%b ctl=%0d exp v=1 ill=1 rw=0 mw=0 ctl=31",
                         i, bus.out_valid, bus.illegal, bus.reg_write, bus.mem_write, bus.alu_ctl);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        exp_t        held;
        logic [31:0] pcs [$];
        logic        sending;
        drive(1'b1, 32'h00208863, 32'h200, 1'b0, 1'b0);
        step();
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_first got rdy=%b v=%b exp rdy=1 v=1", bus.in_ready, bus.out_valid);
        end
        drive(1'b1, 32'h0080A183, 32'h204, 1'b0, 1'b0);
        step();
        held = get_out();
        tests_run++;
        if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_drop got %b exp 0", bus.in_ready); end
        drive(1'b1, 32'h0030A623, 32'h208, 1'b0, 1'b0);
        step();
        tests_run++;
        if (get_out() !== held || held.pc !== 32'h200) begin
            tests_failed++; $display("FAIL b2b_stable got %h exp %h (pc 200)", get_out(), held);
        end
        drive(1'b1, 32'h0030A623, 32'h208, 1'b1, 1'b0);
        sending = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (last_acc) begin sending = 1'b0; bus.in_valid = 1'b0; end
            if (drained) begin
                pcs.push_back(got_drained.pc);
                tests_run++;
                if (got_drained !== exp_drained) begin
                    tests_failed++; $display("FAIL b2b_bundle got %h exp %h", got_drained, exp_drained);
                end
            end
        end
        tests_run++;
        if (sending || pcs.size() != 3 || pcs[0] !== 32'h200 || pcs[1] !== 32'h204 || pcs[2] !== 32'h208) begin
            tests_failed++; $display("FAIL b2b_order got count=%0d exp 3 in order 200,204,208", pcs.size());
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h00100093, 32'h500, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00200113, 32'h504, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00300193, 32'h508, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL flush_full got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            tests_run++;
            if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_quiet got v=%b exp 0", bus.out_valid); end
        end
        drive(1'b1, 32'h00400213, 32'h600, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00500293, 32'h604, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL flush_accept got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_random();
        logic stall;
        exp_t snap;
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 3) != 0), rand_instr(), $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
            tests_run++;
            if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== (q.size() < 2)) begin
                tests_failed++;
                $display("FAIL rand_hs cyc %0d got v=%b rdy=%b exp v=%b rdy=%b",
                         c, bus.out_valid, bus.in_ready, q.size() > 0, q.size() < 2);
            end
            stall = (q.size() > 0) && !bus.out_ready && !bus.flush;
            snap  = get_out();
            step();
            if (stall) begin
                tests_run++;
                if (get_out() !== snap) begin tests_failed++; $display("FAIL rand_stable cyc %0d got %h exp %h", c, get_out(), snap); end
            end
            if (drained) begin
                tests_run++;
                if (got_drained !== exp_drained) begin
                    tests_failed++; $display("FAIL rand_bundle cyc %0d got %h exp %h", c, got_drained, exp_drained);
                end
            end
        end
        drain_all();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h00208863, 32'h700, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h0080A183, 32'h704, 1'b0, 1'b0);
        step();
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL rst_mid_hs got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        tests_run++;
        if (get_out() !== exp_t'(0)) begin tests_failed++; $display("FAIL rst_mid_bundle got %h exp 0", get_out()); end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_after got v=%b exp 0", bus.out_valid); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        drained      = 1'b0;
        last_acc     = 1'b0;
        rst          = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_addi();
        test_jumps();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
